// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding / hazard unit.
// Slot records are sized to upper bounds so widths stay parametrisable.
package fwd_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 3;
  localparam int REG_AW_MAX = 8;
  localparam int NSRC_MAX   = 8;

  typedef logic [REG_AW_MAX-1:0] reg_t;

  typedef struct packed {
    logic                       valid;
    reg_t [NSRC_MAX-1:0]        src;
    logic [NSRC_MAX-1:0]        used;
    reg_t                       dst;
    logic                       wr;
    logic                       load;
  } ex_slot_t;

  typedef struct packed {
    logic valid;
    reg_t dst;
    logic wr;
    logic load;
  } mem_slot_t;

  typedef struct packed {
    logic valid;
    reg_t dst;
    logic wr;
  } wb_slot_t;

  localparam ex_slot_t  EX_BUBBLE  = '0;
  localparam mem_slot_t MEM_BUBBLE = '0;
  localparam wb_slot_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/fwd_mux.sv
// One-operand forwarding mux: MEM result over WB data over raw operand.
// Ports: i_src/i_used (EX source), i_mem/i_wb slots, data in, o_opnd out.
module fwd_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  reg_t              i_src,
  input  logic              i_used,
  input  mem_slot_t         i_mem,
  input  wb_slot_t          i_wb,
  input  logic [DATA_W-1:0] i_mem_result,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_opnd
);

  logic w_mem_hit;
  logic w_wb_hit;

  // A load in MEM only holds its address, so it must never forward.
  assign w_mem_hit = i_used & i_mem.valid & i_mem.wr
                   & ~i_mem.load & (i_mem.dst == i_src);
  assign w_wb_hit  = i_used & i_wb.valid & i_wb.wr
                   & (i_wb.dst == i_src);

  always_comb begin
    o_opnd = i_raw;
    if (w_mem_hit)
      o_opnd = i_mem_result;
    else if (w_wb_hit)
      o_opnd = i_wb_data;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX/MEM/WB destination tracking, operand forwarding, load-use stall,
// cache freeze, issue flush and a saturating load-use stall counter.
// Ports: issue_* (ID instr), flush, mem_stall, stage data in;
//        ex_opnd (forwarded operands), id_stall, stall_cnt out.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [NSRC*REG_AW-1:0] issue_src,
  input  logic [NSRC-1:0]        issue_src_used,
  input  logic [REG_AW-1:0]      issue_dst,
  input  logic                   issue_wr,
  input  logic                   issue_load,
  input  logic                   flush,
  input  logic                   mem_stall,
  input  logic [NSRC*DATA_W-1:0] ex_src_data,
  input  logic [DATA_W-1:0]      mem_result,
  input  logic [DATA_W-1:0]      wb_data,
  output logic [NSRC*DATA_W-1:0] ex_opnd,
  output logic                   id_stall,
  output logic [CNT_W-1:0]       stall_cnt
);

  ex_slot_t   r_ex;
  mem_slot_t  r_mem;
  wb_slot_t   r_wb;
  logic [CNT_W-1:0] r_cnt;

  ex_slot_t   w_issue;
  logic       w_src_hit;
  logic       w_load_use;
  logic       w_unused;

  always_comb begin
    w_src_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (issue_src_used[i] &&
          REG_AW_MAX'(issue_src[i*REG_AW +: REG_AW]) == r_ex.dst)
        w_src_hit = 1'b1;
    end
  end

  assign w_load_use = issue_valid & r_ex.valid & r_ex.wr
                    & r_ex.load & w_src_hit;
  assign id_stall   = w_load_use & ~flush;

  always_comb begin
    w_issue       = EX_BUBBLE;
    w_issue.valid = issue_valid & ~id_stall & ~flush;
    for (int i = 0; i < NSRC; i++) begin
      w_issue.src[i]  = REG_AW_MAX'(issue_src[i*REG_AW +: REG_AW]);
      w_issue.used[i] = issue_src_used[i];
    end
    w_issue.dst  = REG_AW_MAX'(issue_dst);
    w_issue.wr   = issue_wr;
    w_issue.load = issue_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= EX_BUBBLE;
      r_mem <= MEM_BUBBLE;
      r_wb  <= WB_BUBBLE;
      r_cnt <= '0;
    end else if (!mem_stall) begin
      r_wb  <= '{valid: r_mem.valid, dst: r_mem.dst, wr: r_mem.wr};
      r_mem <= '{valid: r_ex.valid, dst: r_ex.dst,
                 wr: r_ex.wr, load: r_ex.load};
      r_ex  <= w_issue;
      if (id_stall && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_cnt;

  for (genvar g = 0; g < NSRC; g++) begin : g_mux
    fwd_mux #(
      .DATA_W(DATA_W)
    ) u_mux (
      .i_src       (r_ex.src[g]),
      .i_used      (r_ex.valid & r_ex.used[g]),
      .i_mem       (r_mem),
      .i_wb        (r_wb),
      .i_mem_result(mem_result),
      .i_wb_data   (wb_data),
      .i_raw       (ex_src_data[g*DATA_W +: DATA_W]),
      .o_opnd      (ex_opnd[g*DATA_W +: DATA_W])
    );
  end

  // Slot lanes above NSRC are sized for the widest build only.
  assign w_unused = ^r_ex;

endmodule
